// File: rtl/screen_ctrl.sv
// screen_ctrl
// Frame-synchronous screen sequencer for the DeathRace video path. It runs the
// title -> countdown -> game -> game-over loop. Every state change, and so every
// change of the one-hot screen selects, lands on a frame tick inside vertical blank.
//
// Optional feature: define SCREEN_CTRL_ATTRACT_EN to add the attract-mode DEMO
// state. Without it, frame_cnt holds 0 in TITLE and demo is tied to 0.
//
// Ports
//   pclk            pixel clock
//   rst_n           asynchronous active-low reset
//   vblnk           vertical blank, synchronous to pclk
//   start_btn       raw asynchronous start button, active-high
//   game_over       one-cycle game-over pulse from game logic
//   TitleScreen_sel selects the title screen (one-hot with GameScreen_sel)
//   GameScreen_sel  selects the game screen
//   game_rst_n      active-low hold-in-reset for game logic
//   game_en         enables game motion and physics
//   demo            attract demo active (game logic uses AI input)
//   state           TITLE=0, COUNTDOWN=1, GAME=2, OVER=3, DEMO=4
//   frame_cnt       frames elapsed in the current state, saturating
module screen_ctrl #(
  parameter int START_FRAMES = 180,
  parameter int OVER_FRAMES  = 300,
  parameter int IDLE_FRAMES  = 1800,
  parameter int DEMO_FRAMES  = 900,
  parameter int CNT_W        = 12
) (
  input  logic             pclk,
  input  logic             rst_n,
  input  logic             vblnk,
  input  logic             start_btn,
  input  logic             game_over,
  output logic             TitleScreen_sel,
  output logic             GameScreen_sel,
  output logic             game_rst_n,
  output logic             game_en,
  output logic             demo,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] frame_cnt
);

  typedef enum logic [2:0] {
    S_TITLE     = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_GAME      = 3'd2,
    S_OVER      = 3'd3,
    S_DEMO      = 3'd4
  } state_t;

  // Terminal count for a frame parameter; 0 behaves like 1 (leave on first tick).
  function automatic logic [CNT_W-1:0] last_of(input int frames);
    if (frames <= 1) return '0;
    return CNT_W'(frames - 1);
  endfunction

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  localparam logic [CNT_W-1:0] START_LAST = last_of(START_FRAMES);
  localparam logic [CNT_W-1:0] OVER_LAST  = last_of(OVER_FRAMES);
`ifdef SCREEN_CTRL_ATTRACT_EN
  localparam logic [CNT_W-1:0] IDLE_LAST  = last_of(IDLE_FRAMES);
  localparam logic [CNT_W-1:0] DEMO_LAST  = last_of(DEMO_FRAMES);
`endif

  // Elaboration-time range check: every frame parameter must fit the counter.
  if (START_FRAMES >= (1 << CNT_W) || OVER_FRAMES >= (1 << CNT_W) ||
      IDLE_FRAMES  >= (1 << CNT_W) || DEMO_FRAMES >= (1 << CNT_W)) begin : g_param_check
    $error("screen_ctrl: frame parameter does not fit in CNT_W bits");
  end

  logic   btn_meta, btn_sync, btn_sync_d, btn_rise;
  logic   vblnk_low_d, tick;
  logic   start_req, over_req;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_d;

  // Input stage: button synchronizer/edge detect, vblank rise tick, sticky requests.
  // vblnk_low_d resets to 0, so a vblnk held high through reset release must
  // first be seen low before it can tick.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta    <= 1'b0;
      btn_sync    <= 1'b0;
      btn_sync_d  <= 1'b0;
      btn_rise    <= 1'b0;
      vblnk_low_d <= 1'b0;
      tick        <= 1'b0;
      start_req   <= 1'b0;
      over_req    <= 1'b0;
    end else begin
      btn_meta    <= start_btn;
      btn_sync    <= btn_meta;
      btn_sync_d  <= btn_sync;
      btn_rise    <= btn_sync & ~btn_sync_d;
      vblnk_low_d <= ~vblnk;
      tick        <= vblnk & vblnk_low_d;
      // A new request in the tick cycle wins over the clear, so it is not lost.
      if (btn_rise)       start_req <= 1'b1;
      else if (tick)      start_req <= 1'b0;
      if (game_over)      over_req  <= 1'b1;
      else if (tick)      over_req  <= 1'b0;
    end
  end

  // Next-state logic: all transitions and count updates are gated by tick,
  // except recovery from an undefined encoding.
  always_comb begin
    state_d = state_q;
    cnt_d   = frame_cnt;
    case (state_q)
      S_TITLE: begin
        if (tick) begin
          if (start_req) state_d = S_COUNTDOWN;
`ifdef SCREEN_CTRL_ATTRACT_EN
          else if (frame_cnt >= IDLE_LAST) state_d = S_DEMO;
          else cnt_d = sat_inc(frame_cnt);
`endif
        end
      end
      S_COUNTDOWN: begin
        if (tick) begin
          if (frame_cnt >= START_LAST) state_d = S_GAME;
          else cnt_d = sat_inc(frame_cnt);
        end
      end
      S_GAME: begin
        if (tick) begin
          if (over_req) state_d = S_OVER;
          else cnt_d = sat_inc(frame_cnt);
        end
      end
      S_OVER: begin
        if (tick) begin
          if (frame_cnt >= OVER_LAST) state_d = S_TITLE;
          else cnt_d = sat_inc(frame_cnt);
        end
      end
`ifdef SCREEN_CTRL_ATTRACT_EN
      S_DEMO: begin
        if (tick) begin
          if (start_req || over_req || frame_cnt >= DEMO_LAST) state_d = S_TITLE;
          else cnt_d = sat_inc(frame_cnt);
        end
      end
`endif
      default: state_d = S_TITLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // State/output stage: outputs decode state_d so they switch on the same edge as state.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_TITLE;
      frame_cnt       <= '0;
      TitleScreen_sel <= 1'b1;
      GameScreen_sel  <= 1'b0;
      game_rst_n      <= 1'b0;
      game_en         <= 1'b0;
      demo            <= 1'b0;
    end else begin
      state_q         <= state_d;
      frame_cnt       <= cnt_d;
      TitleScreen_sel <= (state_d == S_TITLE);
      GameScreen_sel  <= (state_d != S_TITLE);
      game_rst_n      <= (state_d != S_TITLE);
      game_en         <= (state_d == S_GAME) || (state_d == S_DEMO);
`ifdef SCREEN_CTRL_ATTRACT_EN
      demo            <= (state_d == S_DEMO);
`else
      demo            <= 1'b0;
`endif
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_screen_ctrl.sv
// Testbench for screen_ctrl. Expected output transitions (state plus all control
// outputs, the frame in which they must appear, and whether vblnk must be high)
// are queued by the stimulus; a monitor pops one entry per observed change.
module tb_screen_ctrl;

  localparam int CNT_W = 12;

  logic             pclk = 1'b0;
  logic             rst_n = 1'b1;
  logic             vblnk = 1'b0;
  logic             start_btn = 1'b0;
  logic             game_over = 1'b0;
  logic             TitleScreen_sel, GameScreen_sel, game_rst_n, game_en, demo;
  logic [2:0]       state;
  logic [CNT_W-1:0] frame_cnt;

  screen_ctrl #(
    .START_FRAMES(3),
    .OVER_FRAMES (2),
    .IDLE_FRAMES (4),
    .DEMO_FRAMES (5),
    .CNT_W       (CNT_W)
  ) dut (
    .pclk           (pclk),
    .rst_n          (rst_n),
    .vblnk          (vblnk),
    .start_btn      (start_btn),
    .game_over      (game_over),
    .TitleScreen_sel(TitleScreen_sel),
    .GameScreen_sel (GameScreen_sel),
    .game_rst_n     (game_rst_n),
    .game_en        (game_en),
    .demo           (demo),
    .state          (state),
    .frame_cnt      (frame_cnt)
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;
  int frame_no = 0;

  // Frame of 8 cycles: vblnk high for 3, low for 5. frame_no counts vblnk rises.
  initial begin
    int ph;
    ph = 7;
    forever begin
      @(negedge pclk);
      ph = (ph == 7) ? 0 : ph + 1;
      vblnk = (ph < 3);
      if (ph == 0) frame_no++;
    end
  end

  typedef struct {
    logic [7:0] b;       // {state, title, game, game_rst_n, game_en, demo}
    int         frame;   // frame whose tick causes the change, -1 = don't care
    bit         need_vb; // change must be seen while vblnk is high
    int         tag;
  } exp_t;

  exp_t exp_q[$];
  bit   mon_en = 1'b0;
  logic [7:0] last_b;

  function automatic logic [7:0] bundle();
    return {state, TitleScreen_sel, GameScreen_sel, game_rst_n, game_en, demo};
  endfunction

  task automatic push_exp(input int tag, input logic [2:0] st, input logic t, input logic g,
                          input logic gr, input logic en, input logic dm,
                          input int frame, input bit need_vb);
    exp_t e;
    e.b = {st, t, g, gr, en, dm};
    e.frame = frame;
    e.need_vb = need_vb;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input longint act, input longint want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, act, want);
    end
  endtask

  // Monitor: every change of the output bundle must match the next queued entry.
  always @(negedge pclk) begin
    if (mon_en) begin
      logic [7:0] cur;
      exp_t e;
      cur = bundle();
      if (cur !== last_b) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change got=%b prev=%b frame=%0d", cur, last_b, frame_no);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e.b || (e.frame >= 0 && frame_no != e.frame) || (e.need_vb && vblnk !== 1'b1)) begin
            errors++;
            $display("FAIL trans%0d got=%b frame=%0d vblnk=%b want=%b frame=%0d vblnk_high=%0d",
                     e.tag, cur, frame_no, vblnk, e.b, e.frame, e.need_vb);
          end
        end
        last_b = cur;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog_timeout frame=%0d", frame_no);
    $fatal(1, "watchdog");
  end

  // Wait until frame f has started, then return at the vblnk falling edge.
  task automatic wait_frame(input int f);
    wait (frame_no >= f);
    @(negedge vblnk);
  endtask

  task automatic press();
    start_btn = 1'b1;
    repeat (4) @(negedge pclk);
    start_btn = 1'b0;
  endtask

  initial begin
    int f, g, h, r;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge pclk);
    chk("rst_state", state, 0);
    chk("rst_title_sel", TitleScreen_sel, 1);
    chk("rst_game_sel", GameScreen_sel, 0);
    chk("rst_game_rst_n", game_rst_n, 0);
    chk("rst_game_en", game_en, 0);
    chk("rst_demo", demo, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    rst_n = 1'b1;
    last_b = bundle();
    mon_en = 1'b1;

`ifdef SCREEN_CTRL_ATTRACT_EN
    f = frame_no + 2;
`else
    f = frame_no + 10;
`endif
    wait_frame(f);
    chk("idle_state", state, 0);
    chk("idle_game_rst_n", game_rst_n, 0);

    // Title -> countdown -> game with START_FRAMES=3.
    f = frame_no;
    push_exp(1, 3'd1, 0, 1, 1, 0, 0, f + 1, 1);
    push_exp(2, 3'd2, 0, 1, 1, 1, 0, f + 4, 1);
    press();
    wait (frame_no >= f + 3);
    #1 chk("countdown_cnt1", frame_cnt, 1);
    wait (frame_no >= f + 4);
    #1 chk("countdown_cnt2", frame_cnt, 2);
    wait_frame(f + 5);
    chk("game_state", state, 2);
    chk("game_en_high", game_en, 1);

    // Game over plus button in the same frame: button must be ignored.
    g = frame_no;
    push_exp(3, 3'd3, 0, 1, 1, 0, 0, g + 1, 1);
    push_exp(4, 3'd0, 1, 0, 0, 0, 0, g + 3, 1);
    game_over = 1'b1;
    @(negedge pclk);
    game_over = 1'b0;
    press();
    wait_frame(g + 5);
    chk("after_over_state", state, 0);
    chk("after_over_game_rst_n", game_rst_n, 0);

    // Back into game, then asynchronous reset while vblnk is low.
    h = frame_no;
    push_exp(5, 3'd1, 0, 1, 1, 0, 0, h + 1, 1);
    push_exp(6, 3'd2, 0, 1, 1, 1, 0, h + 4, 1);
    press();
    wait_frame(h + 5);
    chk("game2_state", state, 2);
    push_exp(7, 3'd0, 1, 0, 0, 0, 0, -1, 0);
    @(negedge pclk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_vblnk_low", vblnk, 0);
    chk("async_rst_state", state, 0);
    chk("async_rst_title_sel", TitleScreen_sel, 1);
    chk("async_rst_game_sel", GameScreen_sel, 0);
    chk("async_rst_game_en", game_en, 0);
    chk("async_rst_frame_cnt", frame_cnt, 0);
    wait (frame_no >= h + 6);
    @(negedge pclk);
    chk("release_vblnk_high", vblnk, 1);
    rst_n = 1'b1;
    r = frame_no;

`ifdef SCREEN_CTRL_ATTRACT_EN
    // Idle title counting starts at the first fresh vblnk rise after release.
    push_exp(8, 3'd4, 0, 1, 1, 1, 1, r + 4, 1);
    wait_frame(r + 5);
    chk("demo_cnt", frame_cnt, 1);
    chk("demo_flag", demo, 1);
    push_exp(9, 3'd0, 1, 0, 0, 0, 0, r + 6, 1);
    press();
    push_exp(10, 3'd4, 0, 1, 1, 1, 1, r + 10, 1);
    push_exp(11, 3'd0, 1, 0, 0, 0, 0, r + 15, 1);
    wait_frame(r + 16);
    chk("title_after_demo_cnt", frame_cnt, 1);
    chk("title_after_demo_flag", demo, 0);
`else
    // Long idle in title: nothing moves, counter stays at 0.
    for (int i = 1; i <= 4; i++) begin
      wait_frame(r + i * 500);
      chk("long_idle_state", state, 0);
      chk("long_idle_demo", demo, 0);
      chk("long_idle_cnt", frame_cnt, 0);
    end
    f = frame_no;
    push_exp(8, 3'd1, 0, 1, 1, 0, 0, f + 1, 1);
    press();
    wait_frame(f + 2);
    chk("late_countdown_cnt", frame_cnt, 1);
`endif

    repeat (4) @(negedge pclk);
    mon_en = 1'b0;
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_trans%0d want=%b frame=%0d now=%0d", e.tag, e.b, e.frame, frame_no);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
